bcd_convert_ctrl: RTL and testbench



---
 rtl/bcd_convert_ctrl.sv | 142 ++++++++++++++
 tb/tb_bcd_convert_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_ctrl.sv
// bcd_convert_ctrl: 3-digit BCD to binary converter with hex/octal display formatting.
// Optional leading-digit blanking enabled by defining BCONV_BLANK_EN.
module bcd_convert_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [11:0] bcd_in,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err,
    output logic [9:0]  bin_out,
    output logic [15:0] dig_out,
    output logic [3:0]  digit_off
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CONV,
        FMT,
        DONE
    } state_t;

    state_t      state;
    logic        start_d;
    logic        mode_q;
    logic [21:0] sr;
    logic [3:0]  cnt;

    logic [2:0]  bad;
    logic [21:0] sh;
    logic [21:0] adj;
    logic [9:0]  bin;
    logic [15:0] dig_fmt;
    logic [3:0]  off_fmt;

    // Digit validity flags of the captured operand
    always_comb begin
        bad[0] = (sr[13:10] > 4'd9);
        bad[1] = (sr[17:14] > 4'd9);
        bad[2] = (sr[21:18] > 4'd9);
    end

    // One reverse double-dabble step: shift right, then fix BCD digits >= 8
    always_comb begin
        sh  = sr >> 1;
        adj = sh;
        if (sh[13:10] >= 4'd8) adj[13:10] = sh[13:10] - 4'd3;
        if (sh[17:14] >= 4'd8) adj[17:14] = sh[17:14] - 4'd3;
        if (sh[21:18] >= 4'd8) adj[21:18] = sh[21:18] - 4'd3;
    end

    // Display nibble formatting and optional leading-zero blanking
    always_comb begin
        bin = sr[9:0];
        if (mode_q) begin
            dig_fmt = {3'b000, bin[9],
                       1'b0, bin[8:6],
                       1'b0, bin[5:3],
                       1'b0, bin[2:0]};
        end else begin
            dig_fmt = {2'b00, bin[9:8], bin[7:4], bin[3:0]};
        end
`ifdef BCONV_BLANK_EN
        off_fmt[0] = 1'b0;
        off_fmt[3] = (dig_fmt[15:12] == 4'd0);
        off_fmt[2] = off_fmt[3] && (dig_fmt[11:8] == 4'd0);
        off_fmt[1] = off_fmt[2] && (dig_fmt[7:4] == 4'd0);
`else
        off_fmt = 4'b0000;
`endif
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_d   <= 1'b1;
            mode_q    <= 1'b0;
            sr        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= '0;
            bin_out   <= '0;
            dig_out   <= '0;
            digit_off <= '0;
        end else begin
            start_d <= start;
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !start_d) begin
                        sr     <= {bcd_in, 10'd0};
                        mode_q <= mode;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (|bad) begin
                        err       <= bad;
                        bin_out   <= '0;
                        dig_out   <= '0;
                        digit_off <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        err   <= '0;
                        cnt   <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sr  <= adj;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) state <= FMT;
                end
                FMT: begin
                    bin_out   <= bin;
                    dig_out   <= dig_fmt;
                    digit_off <= off_fmt;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Testbench for bcd_convert_ctrl: scoreboard of expected results checked on done.
// Expected blanking follows BCONV_BLANK_EN when defined for the build.
module tb_bcd_convert_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [2:0]  err;
    logic [9:0]  bin_out;
    logic [15:0] dig_out;
    logic [3:0]  digit_off;

    typedef struct packed {
        logic [2:0]  err;
        logic [9:0]  bin;
        logic [15:0] dig;
        logic [3:0]  off;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    bcd_convert_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bin_out   (bin_out),
        .dig_out   (dig_out),
        .digit_off (digit_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal arithmetic and radix division
    function automatic exp_t model(input logic [11:0] b, input logic m);
        exp_t e;
        int   v;
        int   d0, d1, d2, d3;
        e = '0;
        e.err[0] = (b[3:0]  > 9);
        e.err[1] = (b[7:4]  > 9);
        e.err[2] = (b[11:8] > 9);
        if (e.err != 3'b000) return e;
        v = b[11:8] * 100 + b[7:4] * 10 + b[3:0];
        e.bin = v[9:0];
        if (!m) begin
            d0 = v % 16; d1 = (v / 16) % 16; d2 = v / 256; d3 = 0;
        end else begin
            d0 = v % 8; d1 = (v / 8) % 8; d2 = (v / 64) % 8; d3 = v / 512;
        end
        e.dig = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
`ifdef BCONV_BLANK_EN
        e.off[3] = (d3 == 0);
        e.off[2] = (d3 == 0) && (d2 == 0);
        e.off[1] = (d3 == 0) && (d2 == 0) && (d1 == 0);
        e.off[0] = 1'b0;
`endif
        return e;
    endfunction

    task automatic do_conv(input logic [11:0] b, input logic m,
                           input int exp_lat);
        exp_t e;
        int   n;
        int   busy_n;
        bit   seen;
        sb.push_back(model(b, m));
        @(negedge clk);
        bcd_in = b;
        mode   = m;
        start  = 1'b1;
        n = 0; busy_n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) seen = 1;
        end
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL conv_timeout bcd=%h: no done within %0d cycles", b, n);
        end else begin
            checks++;
            if (err !== e.err) begin
                fails++;
                $display("FAIL err bcd=%h m=%0d: got %b want %b", b, m, err, e.err);
            end
            checks++;
            if (bin_out !== e.bin) begin
                fails++;
                $display("FAIL bin bcd=%h: got %0d want %0d", b, bin_out, e.bin);
            end
            checks++;
            if (dig_out !== e.dig) begin
                fails++;
                $display("FAIL dig bcd=%h m=%0d: got %h want %h", b, m, dig_out, e.dig);
            end
            checks++;
            if (digit_off !== e.off) begin
                fails++;
                $display("FAIL off bcd=%h m=%0d: got %b want %b", b, m, digit_off, e.off);
            end
            checks++;
            if (n - 1 !== exp_lat) begin
                fails++;
                $display("FAIL latency bcd=%h: got %0d want %0d", b, n - 1, exp_lat);
            end
            checks++;
            if (busy_n !== exp_lat) begin
                fails++;
                $display("FAIL busy_len bcd=%h: got %0d want %0d", b, busy_n, exp_lat);
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse bcd=%h: got %b want 0", b, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; bcd_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, bin_out, dig_out, digit_off} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got b%b d%b e%b bin%h dig%h off%b want all 0",
                     busy, done, err, bin_out, dig_out, digit_off);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_convert();
        do_conv(12'h999, 1'b0, 12);
        do_conv(12'h999, 1'b1, 12);
        do_conv(12'h000, 1'b0, 12);
        do_conv(12'h512, 1'b1, 12);
        do_conv(12'h008, 1'b0, 12);
        for (int i = 0; i < 4; i++) begin
            logic [11:0] b;
            b = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
            do_conv(b, 1'($urandom_range(1)), 12);
        end
    endtask

    task automatic test_error();
        do_conv(12'h9A5, 1'b0, 1);
        do_conv(12'hFFF, 1'b1, 1);
        do_conv(12'h00C, 1'b0, 1);
    endtask

    task automatic test_hold_start();
        exp_t e;
        int   dones;
        sb.push_back(model(12'h100, 1'b0));
        @(negedge clk);
        bcd_in = 12'h100;
        mode   = 1'b0;
        start  = 1'b1;
        dones  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 5) start = 1'b0;
            if (i == 6) start = 1'b1;
            if (done === 1'b1) begin
                dones++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (dig_out !== e.dig || digit_off !== e.off || bin_out !== e.bin) begin
                        fails++;
                        $display("FAIL hold_result: got bin%0d dig%h off%b want bin%0d dig%h off%b",
                                 bin_out, dig_out, digit_off, e.bin, e.dig, e.off);
                    end
                end
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL hold_done_count: got %0d want 1", dones);
        end
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic test_reset_mid();
        int act;
        @(negedge clk);
        bcd_in = 12'h999;
        mode   = 1'b0;
        start  = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, bin_out, dig_out, digit_off} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got b%b d%b bin%h dig%h off%b want all 0",
                     busy, done, bin_out, dig_out, digit_off);
        end
        act = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) act++;
        end
        checks++;
        if (act !== 0) begin
            fails++;
            $display("FAIL midreset_idle: got %0d active cycles want 0", act);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        do_conv(12'h042, 1'b1, 12);
    endtask

    initial begin
        test_reset();
        test_convert();
        test_error();
        test_hold_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
